// File: rtl/demux1_2_reg_pkg.sv
// demux1_2_reg_pkg: shared port selectors, default widths and holding-stage states
package demux1_2_reg_pkg;
  localparam logic SEL_P1 = 1'b0;
  localparam logic SEL_P2 = 1'b1;
  localparam int N_DEF = 32;
  localparam int CNT_W_DEF = 16;
  typedef enum logic {EMPTY, FULL} state_t;
endpackage

// File: rtl/demux1_2_reg_counter.sv
// xfer_counter: wrapping transfer counter, cleared by synchronous reset
module xfer_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);
  logic [CNT_W-1:0] cnt_q;
  always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_q + CNT_W'(inc);
  assign cnt = cnt_q;
endmodule

// File: rtl/demux1_2_reg.sv
// demux1_2_reg: registered 1-to-2 valid/ready demultiplexer with per-port transfer counters
module demux1_2_reg
  import demux1_2_reg_pkg::*;
#(
  parameter int n     = N_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [n-1:0]     di,
  input  logic             sel,
  input  logic             di_valid,
  output logic             di_ready,
  output logic [n-1:0]     do1,
  output logic             do1_valid,
  input  logic             do1_ready,
  output logic [n-1:0]     do2,
  output logic             do2_valid,
  input  logic             do2_ready,
  output logic [CNT_W-1:0] cnt1,
  output logic [CNT_W-1:0] cnt2
);
  state_t state_q, state_d;
  logic [n-1:0] data_q, data_d;
  logic sel_q, sel_d;
  logic out_take, in_take;
  assign out_take = (state_q == FULL) && (sel_q == SEL_P2 ? do2_ready : do1_ready);
  assign di_ready = (state_q == EMPTY) || out_take;
  assign in_take  = di_valid && di_ready;
  always_comb begin
    state_d = in_take ? FULL : out_take ? EMPTY : state_q;
    data_d  = in_take ? di : data_q;
    sel_d   = in_take ? sel : sel_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      data_q  <= '0;
      sel_q   <= SEL_P1;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
    end
  end
  assign do1       = data_q;
  assign do2       = data_q;
  assign do1_valid = (state_q == FULL) && (sel_q == SEL_P1);
  assign do2_valid = (state_q == FULL) && (sel_q == SEL_P2);
  xfer_counter #(.CNT_W(CNT_W)) u_cnt1 (
    .clk(clk), .rst(rst), .inc(do1_valid && do1_ready), .cnt(cnt1)
  );
  xfer_counter #(.CNT_W(CNT_W)) u_cnt2 (
    .clk(clk), .rst(rst), .inc(do2_valid && do2_ready), .cnt(cnt2)
  );
endmodule

// File: tb/tb_demux1_2_reg.sv
// tb_demux1_2_reg: randomized + directed bench against a one-slot queue model of the demux
module tb_demux1_2_reg;
  logic clk = 0, rst = 1;
  logic [31:0] di = 0;
  logic sel = 0, di_valid = 0, do1_ready = 0, do2_ready = 0;
  logic di_ready, do1_valid, do2_valid;
  logic [31:0] do1, do2;
  logic [15:0] cnt1, cnt2;
  logic di_ready4, do1_valid4, do2_valid4;
  logic [31:0] do1_4, do2_4;
  logic [3:0] cnt1_4, cnt2_4;
  int n_chk = 0, n_pass = 0;
  bit en = 0;
  always #5 clk = ~clk;

  demux1_2_reg dut (
    .clk(clk), .rst(rst), .di(di), .sel(sel), .di_valid(di_valid), .di_ready(di_ready),
    .do1(do1), .do1_valid(do1_valid), .do1_ready(do1_ready),
    .do2(do2), .do2_valid(do2_valid), .do2_ready(do2_ready), .cnt1(cnt1), .cnt2(cnt2)
  );
  demux1_2_reg #(.n(32), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .di(di), .sel(sel), .di_valid(di_valid), .di_ready(di_ready4),
    .do1(do1_4), .do1_valid(do1_valid4), .do1_ready(do1_ready),
    .do2(do2_4), .do2_valid(do2_valid4), .do2_ready(do2_ready), .cnt1(cnt1_4), .cnt2(cnt2_4)
  );

  typedef struct {logic [31:0] d; bit p;} word_t;
  word_t q[$];
  int c[2];
  logic [31:0] last_d = 0;

  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      c[0] = 0;
      c[1] = 0;
      last_d = 0;
    end else begin
      bit pop, push;
      pop  = q.size() > 0 && (q[0].p ? do2_ready : do1_ready);
      push = di_valid && (q.size() == 0 || pop);
      if (pop) begin
        c[q[0].p]++;
        void'(q.pop_front());
      end
      if (push) begin
        q.push_back('{d: di, p: sel});
        last_d = di;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  always @(negedge clk) if (en) begin
    bit full, p;
    full = q.size() > 0;
    p = full ? q[0].p : 1'b0;
    chk("di_ready", {31'b0, di_ready}, {31'b0, !full || (p ? do2_ready : do1_ready)});
    chk("do1_valid", {31'b0, do1_valid}, {31'b0, full && !p});
    chk("do2_valid", {31'b0, do2_valid}, {31'b0, full && p});
    chk("do1", do1, last_d);
    chk("do2", do2, last_d);
    chk("cnt1", {16'b0, cnt1}, c[0] % 65536);
    chk("cnt2", {16'b0, cnt2}, c[1] % 65536);
    chk("cnt1_w4", {28'b0, cnt1_4}, c[0] % 16);
    chk("cnt2_w4", {28'b0, cnt2_4}, c[1] % 16);
  end

  task automatic cyc(); @(posedge clk); #1; endtask
  task automatic look(); @(negedge clk); endtask

  initial begin
    cyc();
    en = 1;
    cyc();
    rst = 0;
    look();
    chk("rst_do1_valid", {31'b0, do1_valid}, 0);
    chk("rst_do2_valid", {31'b0, do2_valid}, 0);
    chk("rst_di_ready", {31'b0, di_ready}, 1);
    chk("rst_cnt", {cnt1, cnt2}, 0);
    chk("rst_do1", do1, 0);
    cyc();
    di = 32'hDEADBEEF; sel = 0; di_valid = 1; do1_ready = 1; do2_ready = 1;
    cyc();
    di_valid = 0;
    look();
    chk("single_valid", {30'b0, do1_valid, do2_valid}, 2);
    chk("single_do1", do1, 32'hDEADBEEF);
    cyc();
    look();
    chk("single_cnt", {cnt1, cnt2}, {16'd1, 16'd0});
    cyc();
    for (int i = 1; i <= 8; i++) begin
      di = i; sel = (i % 2 == 0); di_valid = 1;
      look();
      chk("b2b_ready", {31'b0, di_ready}, 1);
      if (i > 1) chk("b2b_order", (i % 2 == 0) ? do1 : do2, i - 1);
      cyc();
    end
    di_valid = 0;
    cyc(); cyc();
    look();
    chk("b2b_cnt", {cnt1, cnt2}, {16'd5, 16'd4});
    cyc();
    di = 32'hA5; sel = 1; di_valid = 1; do2_ready = 0;
    cyc();
    di = 32'h77; sel = 0;
    for (int k = 0; k < 5; k++) begin
      do1_ready = k[0];
      look();
      chk("stall_valid", {30'b0, do1_valid, do2_valid}, 1);
      chk("stall_do2", do2, 32'hA5);
      chk("stall_ready", {31'b0, di_ready}, 0);
      cyc();
    end
    do2_ready = 1; do1_ready = 0;
    cyc();
    di_valid = 0;
    look();
    chk("stall_cnt2", {16'b0, cnt2}, 5);
    chk("stall_next", do1_valid ? do1 : 0, 32'h77);
    do1_ready = 1;
    cyc();
    for (int j = 1; j <= 11; j++) begin
      di = 32'h100 + j; sel = 0; di_valid = 1;
      cyc();
      di_valid = 0;
      cyc();
      look();
      if (j == 9) chk("wrap_15", {28'b0, cnt1_4}, 15);
      if (j == 10) chk("wrap_0", {28'b0, cnt1_4}, 0);
      if (j == 11) chk("wrap_1", {28'b0, cnt1_4}, 1);
    end
    chk("wrap_wide", {16'b0, cnt1}, 17);
    cyc();
    di = 32'hBB; sel = 0; di_valid = 1; do1_ready = 0;
    cyc();
    di_valid = 0;
    look();
    chk("mid_full", {31'b0, do1_valid}, 1);
    rst = 1;
    cyc();
    look();
    chk("mid_rst_valid", {31'b0, do1_valid}, 0);
    chk("mid_rst_cnt", {cnt1, cnt2}, 0);
    rst = 0; do1_ready = 1;
    cyc();
    look();
    chk("mid_no_word", {30'b0, do1_valid, do2_valid}, 0);
    cyc();
    for (int t = 0; t < 3000; t++) begin
      di = $urandom; sel = $urandom_range(0, 1); di_valid = $urandom_range(0, 2) != 0;
      do1_ready = $urandom_range(0, 3) != 0; do2_ready = $urandom_range(0, 3) != 0;
      rst = $urandom_range(0, 199) == 0;
      cyc();
    end
    rst = 0;
    look();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
